// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage PC generator.
package pc_pkg;

    localparam int ILEN_BYTES = 4;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

    typedef enum logic [2:0] {TRAP, REDIR, POP, SEQ, HOLD} sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] push_addr_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, wr_idx;
    logic [PW:0]     cnt_q, cnt_d;
    logic            do_pop, do_push;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PW+1)'(RAS_DEPTH);
    assign top_o   = mem_q[ptr_q];
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && !clear_i;
    // A simultaneous pop consumes the old top, so the push reuses its slot.
    assign wr_idx  = do_pop ? ptr_q : ptr_q + PW'(1);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (do_push && !do_pop) begin
            ptr_d = ptr_q + PW'(1);
            cnt_d = full_o ? cnt_q : cnt_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_idx] <= push_addr_i;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with valid/ready handshake, trap/redirect
// priority mux and return-address prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready_i,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            trap_valid_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            ret_pop_i,
    input  logic            call_push_i,
    input  logic [XLEN-1:0] push_addr_i,
    input  logic            halt_req_i,
    output logic            misalign_err_o,
    output logic            ras_empty_err_o
);
    state_e          state_q, state_d;
    sel_e            sel;
    logic [XLEN-1:0] pc_q, pc_d, ras_top;
    logic            mis_q, mis_d, emp_q, emp_d;
    logic            ras_empty, accept, ctrl, running, misaligned, pop_req;

    assign running    = state_q == RUN;
    assign accept     = running && fetch_ready_i;
    assign ctrl       = state_q != BOOT && (trap_valid_i || redirect_valid_i);
    assign misaligned = redirect_target_i[1:0] != 2'b00;
    // Halt freezes the PC, so it also suppresses accept-driven pops.
    assign pop_req    = accept && !halt_req_i && ret_pop_i;

    always_comb begin
        sel     = ctrl ? (trap_valid_i ? TRAP : REDIR)
                : (accept && !halt_req_i) ? (ret_pop_i && !ras_empty ? POP : SEQ)
                : HOLD;
        pc_d    = sel == TRAP  ? TRAP_VEC
                : sel == REDIR ? (misaligned ? TRAP_VEC : redirect_target_i)
                : sel == POP   ? ras_top
                : sel == SEQ   ? pc_q + XLEN'(ILEN_BYTES)
                : pc_q;
        state_d = (state_q == BOOT || ctrl) ? RUN
                : (running && halt_req_i) ? HALTED
                : state_q;
        mis_d   = sel == REDIR && misaligned;
        emp_d   = !ctrl && pop_req && ras_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
            emp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            emp_q   <= emp_d;
        end
    end

    pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (running && call_push_i),
        .pop_i       (sel == POP),
        .clear_i     (sel == TRAP),
        .push_addr_i (push_addr_i),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      ()
    );

    assign pc_o            = pc_q;
    assign pc_valid_o      = running;
    assign misalign_err_o  = mis_q;
    assign ras_empty_err_o = emp_q;

endmodule
